diaosi_mem_arb: RTL and testbench

Single-port memory arbiter between the pipeline's instruction-fetch and data-access paths. It grants one requester at a time to the shared RAM port and latches that requester's address and store data. It then waits for the RAM ready signal and returns the load data with a one-cycle wait-release pulse. It sits between the fetch/MEM stages and the RAM model; the data side has priority by default.

---
 rtl/diaosi_mem_arb.sv | 126 ++++++++++++
 tb/tb_diaosi_mem_arb.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/diaosi_mem_arb.sv
// diaosi_mem_arb: single-port RAM arbiter between instruction fetch and data access.
// DIAOSI_ARB_RR_EN selects alternating priority; otherwise the data side always wins.
module diaosi_mem_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TIMEOUT = 64,
   parameter logic [DATA_W-1:0] ERR_WORD = 32'hBAD0BAD0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   output logic              ram_ren,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_store,
   input  logic [DATA_W-1:0] ram_load,
   input  logic              ram_ready,
   output logic              arb_err
);
   localparam logic [2:0] IDLE = 3'd0, I_ACC = 3'd1, D_ACC = 3'd2, I_RESP = 3'd3, D_RESP = 3'd4;
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   logic [2:0] state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic ren_q, ren_d, wen_q, wen_d, err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] store_q, store_d, iload_q, iload_d, dload_q, dload_d;
   logic dreq, gnt_d, is_acc, done;

   assign dreq = dREN | dWEN;
`ifdef DIAOSI_ARB_RR_EN
   logic last_q;
   // last_q=1 means data was granted last, so a tie goes to the instruction side
   assign gnt_d = dreq & ~(iREN & last_q);
   always_ff @(posedge CLK)
      if (RST) last_q <= 1'b0;
      else if (state_q == IDLE && (dreq | iREN)) last_q <= gnt_d;
`else
   assign gnt_d = dreq;
`endif

   assign is_acc = state_q == I_ACC || state_q == D_ACC;
   assign done = ram_ready || cnt_q == CNT_MAX;

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      ren_d = ren_q;
      wen_d = wen_q;
      addr_d = addr_q;
      store_d = store_q;
      iload_d = iload_q;
      dload_d = dload_q;
      err_d = 1'b0;
      if (state_q == IDLE) begin
         if (gnt_d) begin
            state_d = D_ACC;
            addr_d = daddr;
            store_d = dstore;
            wen_d = dWEN;
            ren_d = dREN & ~dWEN;
         end else if (iREN) begin
            state_d = I_ACC;
            addr_d = iaddr;
            ren_d = 1'b1;
         end
      end else if (is_acc) begin
         cnt_d = cnt_q + 1'b1;
         if (done) begin
            cnt_d = '0;
            ren_d = 1'b0;
            wen_d = 1'b0;
            err_d = ~ram_ready;
            state_d = state_q == I_ACC ? I_RESP : D_RESP;
            if (state_q == I_ACC) iload_d = ram_ready ? ram_load : ERR_WORD;
            else if (!ram_ready || !wen_q) dload_d = ram_ready ? ram_load : ERR_WORD;
         end
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q <= '0;
         ren_q <= 1'b0;
         wen_q <= 1'b0;
         err_q <= 1'b0;
         addr_q <= '0;
         store_q <= '0;
         iload_q <= '0;
         dload_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ren_q <= ren_d;
         wen_q <= wen_d;
         err_q <= err_d;
         addr_q <= addr_d;
         store_q <= store_d;
         iload_q <= iload_d;
         dload_q <= dload_d;
      end
   end

   assign iwait = iREN & (state_q != I_RESP);
   assign dwait = dreq & (state_q != D_RESP);
   assign iload = iload_q;
   assign dload = dload_q;
   assign ram_ren = ren_q;
   assign ram_wen = wen_q;
   assign ram_addr = addr_q;
   assign ram_store = store_q;
   assign arb_err = err_q;
endmodule

// File: tb/tb_diaosi_mem_arb.sv
// tb_diaosi_mem_arb: directed and random transactions checked against a transaction-level model.
module tb_diaosi_mem_arb;
   localparam int TO = 64;
   localparam logic [31:0] ERR = 32'hBAD0BAD0;

   logic CLK = 1'b0, RST = 1'b1;
   logic iREN = 0, dREN = 0, dWEN = 0, ram_ready = 0;
   logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ram_load = 0;
   logic iwait, dwait, ram_ren, ram_wen, arb_err;
   logic [31:0] iload, dload, ram_addr, ram_store;

   int total = 0, bad = 0;
   logic [31:0] m_addr = 0, m_store = 0, m_iload = 0, m_dload = 0;
   bit m_last_data = 0;

   diaosi_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ERR_WORD(ERR)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
      .ram_load(ram_load), .ram_ready(ram_ready), .arb_err(arb_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = 0;
      m_store = 0;
      m_iload = 0;
      m_dload = 0;
      m_last_data = 0;
   endtask

   // lat = number of ACC cycles before ram_ready; lat >= TO means ram_ready never comes
   task automatic run_txn(input bit ir, input bit dr, input bit dw, input logic [31:0] ia,
                          input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
                          input int lat);
      bit dq, gd, wr, to;
      int acc;
      dq = dr | dw;
`ifdef DIAOSI_ARB_RR_EN
      gd = (dq && ir) ? !m_last_data : dq;
`else
      gd = dq;
`endif
      wr = gd && dw;
      to = lat >= TO;
      acc = to ? TO : lat + 1;
      iREN = ir; dREN = dr; dWEN = dw;
      iaddr = ia; daddr = da; dstore = ds; ram_load = rl; ram_ready = 0;
      @(negedge CLK);
      m_addr = gd ? da : ia;
      if (gd) m_store = ds;
      if (dq || ir) m_last_data = gd;
      for (int c = 0; c < acc; c++) begin
         ram_ready = !to && c == lat;
         chk("acc_ren", ram_ren, !wr);
         chk("acc_wen", ram_wen, wr);
         chk("acc_addr", ram_addr, m_addr);
         chk("acc_store", ram_store, m_store);
         chk("acc_iwait", iwait, ir);
         chk("acc_dwait", dwait, dq);
         chk("acc_err", arb_err, 0);
         @(negedge CLK);
      end
      ram_ready = 0;
      if (to) begin
         if (gd) m_dload = ERR; else m_iload = ERR;
      end else if (gd) begin
         if (!wr) m_dload = rl;
      end else m_iload = rl;
      chk("resp_ren", ram_ren, 0);
      chk("resp_wen", ram_wen, 0);
      chk("resp_err", arb_err, to);
      chk("resp_iwait", iwait, ir && gd);
      chk("resp_dwait", dwait, dq && !gd);
      chk("resp_iload", iload, m_iload);
      chk("resp_dload", dload, m_dload);
      @(negedge CLK);
      iREN = 0; dREN = 0; dWEN = 0;
      chk("idle_ren", ram_ren, 0);
      chk("idle_wen", ram_wen, 0);
      chk("idle_err", arb_err, 0);
   endtask

   initial begin
      iREN = 1; dWEN = 1;
      repeat (2) @(negedge CLK);
      chk("rst_ren", ram_ren, 0);
      chk("rst_wen", ram_wen, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_store", ram_store, 0);
      chk("rst_iload", iload, 0);
      chk("rst_dload", dload, 0);
      chk("rst_err", arb_err, 0);
      chk("rst_iwait", iwait, 1);
      chk("rst_dwait", dwait, 1);
      iREN = 0; dWEN = 0; RST = 0;
      @(negedge CLK);
      run_txn(1, 0, 0, 32'h40, 0, 0, 32'h8C220004, 0);
      run_txn(0, 1, 1, 0, 32'h100, 32'hDEADBEEF, 32'h12345678, 3);
      for (int k = 0; k < 4; k++) run_txn(1, 1, 0, 32'h200 + k * 4, 32'h300 + k * 4, 0, 32'hA000 + k, 0);
      run_txn(0, 1, 0, 32'h44, 32'h500, 32'h77, 32'h55, TO + 10);
      run_txn(1, 0, 0, 32'h48, 0, 0, 32'h66, TO + 10);
      run_txn(0, 1, 0, 0, 32'h600, 0, 32'h99, TO - 1);
      // reset in the second D_ACC cycle abandons the access silently
      dREN = 1; daddr = 32'h700;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1;
      @(negedge CLK);
      model_reset();
      chk("mid_rst_ren", ram_ren, 0);
      chk("mid_rst_wen", ram_wen, 0);
      chk("mid_rst_err", arb_err, 0);
      chk("mid_rst_addr", ram_addr, 0);
      chk("mid_rst_dload", dload, 0);
      chk("mid_rst_dwait", dwait, 1);
      RST = 0; dREN = 0;
      @(negedge CLK);
      run_txn(1, 1, 0, 32'h800, 32'h900, 0, 32'hCAFE, 1);
      // ram_ready in IDLE is ignored
      ram_ready = 1; ram_load = 32'hFFFF0000;
      @(negedge CLK);
      ram_ready = 0;
      chk("idle_rdy_ren", ram_ren, 0);
      chk("idle_rdy_addr", ram_addr, m_addr);
      chk("idle_rdy_iload", iload, m_iload);
      chk("idle_rdy_dload", dload, m_dload);
      chk("idle_rdy_err", arb_err, 0);
      @(negedge CLK);
      chk("idle_rdy_ren2", ram_ren, 0);
      chk("idle_rdy_wen2", ram_wen, 0);
      for (int n = 0; n < 80; n++) begin
         bit ir, dr, dw;
         int lat;
         ir = 1'($urandom_range(0, 1));
         dr = 1'($urandom_range(0, 1));
         dw = 1'($urandom_range(0, 1));
         if (!ir && !dr && !dw) ir = 1;
         lat = ($urandom_range(0, 11) == 0) ? TO + 5 : int'($urandom_range(0, 4));
         run_txn(ir, dr, dw, $urandom, $urandom, $urandom, $urandom, lat);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
